// File: rtl/calc_control_multi.sv
`default_nettype none
// ============================================================================
// Module   : calc_control_multi
// Purpose  : Key-pulse sequencer for a two-operand calculator with ALU handshake.
// Revision : 1.0  initial release
// ============================================================================
module calc_control_multi #(
  parameter int MAX_DIGITS  = 4,
  parameter int CNT_W       = 3,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dig_in,
  input  logic             sub_in,
  input  logic             op_in,
  input  logic             ex_in,
  input  logic             bksp_in,
  input  logic             clr_in,
  input  logic             MS_in,
  input  logic             MR_in,
  input  logic             MC_in,
  input  logic             alu_done_in,
  input  logic             alu_err_in,
  output logic             load_A,
  output logic             load_B,
  output logic             bksp_A,
  output logic             bksp_B,
  output logic             load_A_mem,
  output logic             load_B_mem,
  output logic             load_mem,
  output logic             clear_mem,
  output logic             load_op,
  output logic             execute,
  output logic             chain_A,
  output logic             reset_out,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] digit_cnt,
  output logic [1:0]       display_select
);

  localparam int TMO_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_A_NEG  = 4'd1;
  localparam logic [3:0] S_A      = 4'd2;
  localparam logic [3:0] S_OPR    = 4'd3;
  localparam logic [3:0] S_B_NEG  = 4'd4;
  localparam logic [3:0] S_B      = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_RESULT = 4'd7;
  localparam logic [3:0] S_ERROR  = 4'd8;

  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_max_cnt  = CNT_W'(MAX_DIGITS);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(ALU_TIMEOUT - 1);

  logic [3:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_neg, w_neg_nxt;
  logic [TMO_W-1:0] r_wcnt, w_wcnt_nxt;

  logic w_ld, w_ldm, w_bk, w_lop, w_exe, w_chain, w_rst;
  logic w_k_clr, w_k_ex, w_k_op, w_k_sub, w_k_dig, w_k_mr, w_k_bk;
  logic w_side_b, w_mem_ok;
  logic [3:0] w_empty_st, w_neg_st, w_dig_st;

  // Only the highest-priority pulse present is acted on.
  assign w_k_clr = clr_in;
  assign w_k_ex  = !clr_in && ex_in;
  assign w_k_op  = !clr_in && op_in;
  assign w_k_sub = !clr_in && !ex_in && !op_in && sub_in;
  assign w_k_dig = !clr_in && !ex_in && !op_in && !sub_in && dig_in;
  assign w_k_mr  = !clr_in && !ex_in && !op_in && !sub_in && !dig_in && MR_in;
  assign w_k_bk  = !clr_in && !ex_in && !op_in && !sub_in && !dig_in && !MR_in && bksp_in;

  // A and B editing share one set of transitions, steered by which operand is live.
  assign w_side_b   = (r_state == S_OPR) || (r_state == S_B_NEG) || (r_state == S_B);
  assign w_empty_st = w_side_b ? S_OPR   : S_START;
  assign w_neg_st   = w_side_b ? S_B_NEG : S_A_NEG;
  assign w_dig_st   = w_side_b ? S_B     : S_A;
  assign w_mem_ok   = (r_state != S_WAIT) && (r_state != S_ERROR);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_neg_nxt   = r_neg;
    w_wcnt_nxt  = r_wcnt;
    w_ld        = 1'b0;
    w_ldm       = 1'b0;
    w_bk        = 1'b0;
    w_lop       = 1'b0;
    w_exe       = 1'b0;
    w_chain     = 1'b0;
    w_rst       = 1'b0;
    if (w_k_clr) begin
      w_state_nxt = S_START;
      w_cnt_nxt   = '0;
      w_neg_nxt   = 1'b0;
      w_rst       = 1'b1;
    end else begin
      case (r_state)
        S_START, S_OPR: begin
          if (w_k_sub) begin
            w_ld        = 1'b1;
            w_neg_nxt   = 1'b1;
            w_state_nxt = w_neg_st;
          end else if (w_k_dig) begin
            w_ld        = 1'b1;
            w_neg_nxt   = 1'b0;
            w_cnt_nxt   = c_one;
            w_state_nxt = w_dig_st;
          end else if (w_k_mr) begin
            w_ldm       = 1'b1;
            w_neg_nxt   = 1'b0;
            w_cnt_nxt   = c_max_cnt;
            w_state_nxt = w_dig_st;
          end else if (r_state == S_START) begin
            w_rst = 1'b1;
          end
        end
        S_A_NEG, S_B_NEG: begin
          if (w_k_sub || w_k_bk) begin
            w_bk        = 1'b1;
            w_neg_nxt   = 1'b0;
            w_state_nxt = w_empty_st;
          end else if (w_k_dig) begin
            w_ld        = 1'b1;
            w_cnt_nxt   = c_one;
            w_state_nxt = w_dig_st;
          end else if (w_k_mr) begin
            w_ldm       = 1'b1;
            w_cnt_nxt   = c_max_cnt;
            w_state_nxt = w_dig_st;
          end
        end
        S_A, S_B: begin
          if (w_k_op && !w_side_b) begin
            w_lop       = 1'b1;
            w_cnt_nxt   = '0;
            w_neg_nxt   = 1'b0;
            w_state_nxt = S_OPR;
          end else if (w_k_ex && w_side_b) begin
            w_exe       = 1'b1;
            w_wcnt_nxt  = '0;
            w_state_nxt = S_WAIT;
          end else if (w_k_dig) begin
            if (r_cnt < c_max_cnt) begin
              w_ld      = 1'b1;
              w_cnt_nxt = r_cnt + c_one;
            end
          end else if (w_k_mr) begin
            w_ldm     = 1'b1;
            w_cnt_nxt = c_max_cnt;
          end else if (w_k_bk) begin
            w_bk      = 1'b1;
            w_cnt_nxt = r_cnt - c_one;
            // Removing the last digit leaves only the sign, if there was one.
            if (r_cnt == c_one) begin
              w_state_nxt = r_neg ? w_neg_st : w_empty_st;
            end
          end
        end
        S_WAIT: begin
          if (alu_done_in) begin
            w_state_nxt = alu_err_in ? S_ERROR : S_RESULT;
          end else if (r_wcnt == c_tmo_last) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_wcnt_nxt = r_wcnt + TMO_W'(1);
          end
        end
        S_RESULT: begin
          if (w_k_op) begin
            w_chain     = 1'b1;
            w_lop       = 1'b1;
            w_cnt_nxt   = '0;
            w_neg_nxt   = 1'b0;
            w_state_nxt = S_OPR;
          end
        end
        S_ERROR: begin
        end
        default: begin
          w_state_nxt = S_START;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_neg   <= w_neg_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Mealy strobes are forced low while reset is held.
  assign load_A     = reset_n && w_ld  && !w_side_b;
  assign load_B     = reset_n && w_ld  &&  w_side_b;
  assign bksp_A     = reset_n && w_bk  && !w_side_b;
  assign bksp_B     = reset_n && w_bk  &&  w_side_b;
  assign load_A_mem = reset_n && w_ldm && !w_side_b;
  assign load_B_mem = reset_n && w_ldm &&  w_side_b;
  assign load_mem   = reset_n && MS_in && w_mem_ok;
  assign clear_mem  = reset_n && MC_in && w_mem_ok;
  assign load_op    = reset_n && w_lop;
  assign execute    = reset_n && w_exe;
  assign chain_A    = reset_n && w_chain;
  assign reset_out  = reset_n && w_rst;

  assign busy      = (r_state == S_WAIT);
  assign err       = (r_state == S_ERROR);
  assign digit_cnt = r_cnt;

  always_comb begin
    case (r_state)
      S_OPR, S_B_NEG, S_B, S_WAIT: display_select = 2'b01;
      S_RESULT:                    display_select = 2'b10;
      S_ERROR:                     display_select = 2'b11;
      default:                     display_select = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_control_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_control_multi
// Purpose  : Directed and random key sequences against an operand-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_control_multi;

  localparam int MAX_DIGITS  = 4;
  localparam int CNT_W       = 3;
  localparam int ALU_TIMEOUT = 16;

  localparam logic [10:0] K_NONE = 11'h000;
  localparam logic [10:0] K_DIG  = 11'h001;
  localparam logic [10:0] K_SUB  = 11'h002;
  localparam logic [10:0] K_OP   = 11'h004;
  localparam logic [10:0] K_EX   = 11'h008;
  localparam logic [10:0] K_BK   = 11'h010;
  localparam logic [10:0] K_CLR  = 11'h020;
  localparam logic [10:0] K_MR   = 11'h040;
  localparam logic [10:0] K_MS   = 11'h080;
  localparam logic [10:0] K_MC   = 11'h100;
  localparam logic [10:0] K_DONE = 11'h200;
  localparam logic [10:0] K_AERR = 11'h400;

  // Model phases: which operand is being typed, or where the ALU exchange stands.
  localparam int PH_A = 0, PH_B = 1, PH_W = 2, PH_R = 3, PH_E = 4;
  localparam int SEL_NONE = 0, SEL_CLR = 1, SEL_EXOP = 2, SEL_SUB = 3;
  localparam int SEL_DIG = 4, SEL_MR = 5, SEL_BK = 6;

  logic clock = 1'b0;
  logic reset_n;
  logic dig_in, sub_in, op_in, ex_in, bksp_in, clr_in, MS_in, MR_in, MC_in;
  logic alu_done_in, alu_err_in;
  logic load_A, load_B, bksp_A, bksp_B, load_A_mem, load_B_mem;
  logic load_mem, clear_mem, load_op, execute, chain_A, reset_out;
  logic busy, err;
  logic [CNT_W-1:0] digit_cnt;
  logic [1:0] display_select;

  calc_control_multi #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W),
    .ALU_TIMEOUT(ALU_TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .dig_in(dig_in), .sub_in(sub_in), .op_in(op_in), .ex_in(ex_in),
    .bksp_in(bksp_in), .clr_in(clr_in), .MS_in(MS_in), .MR_in(MR_in), .MC_in(MC_in),
    .alu_done_in(alu_done_in), .alu_err_in(alu_err_in),
    .load_A(load_A), .load_B(load_B), .bksp_A(bksp_A), .bksp_B(bksp_B),
    .load_A_mem(load_A_mem), .load_B_mem(load_B_mem),
    .load_mem(load_mem), .clear_mem(clear_mem),
    .load_op(load_op), .execute(execute), .chain_A(chain_A), .reset_out(reset_out),
    .busy(busy), .err(err), .digit_cnt(digit_cnt), .display_select(display_select)
  );

  always #5 clock = ~clock;

  logic [11:0] w_obs_str;
  logic [6:0]  w_obs_reg;
  assign w_obs_str = {load_A, load_B, bksp_A, bksp_B, load_A_mem, load_B_mem,
                      load_mem, clear_mem, load_op, execute, chain_A, reset_out};
  assign w_obs_reg = {busy, err, display_select, digit_cnt};

  int n_chk = 0;
  int n_err = 0;
  int cyc_no = 0;

  int ph = PH_A;
  bit sg = 1'b0;
  int nd = 0;
  int wc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_keys(input logic [10:0] k);
    dig_in = k[0]; sub_in = k[1]; op_in = k[2]; ex_in = k[3]; bksp_in = k[4];
    clr_in = k[5]; MR_in = k[6]; MS_in = k[7]; MC_in = k[8];
    alu_done_in = k[9]; alu_err_in = k[10];
  endtask

  function automatic logic [6:0] exp_regs();
    logic [1:0] disp;
    case (ph)
      PH_B, PH_W: disp = 2'b01;
      PH_R:       disp = 2'b10;
      PH_E:       disp = 2'b11;
      default:    disp = 2'b00;
    endcase
    return {ph == PH_W, ph == PH_E, disp, CNT_W'(nd)};
  endfunction

  task automatic model_step(input logic [10:0] k, output logic [11:0] es);
    int sel;
    bit ld, bk, ldm, lop, exe, chn, rso, mem_ok, idle_start, side_b;
    ld = 0; bk = 0; ldm = 0; lop = 0; exe = 0; chn = 0; rso = 0;
    side_b     = (ph == PH_B);
    idle_start = (ph == PH_A) && (nd == 0) && !sg;
    mem_ok     = (ph != PH_W) && (ph != PH_E);
    if (k[5])              sel = SEL_CLR;
    else if (k[2] || k[3]) sel = SEL_EXOP;
    else if (k[1])         sel = SEL_SUB;
    else if (k[0])         sel = SEL_DIG;
    else if (k[6])         sel = SEL_MR;
    else if (k[4])         sel = SEL_BK;
    else                   sel = SEL_NONE;
    if (sel == SEL_CLR) begin
      rso = 1; ph = PH_A; nd = 0; sg = 0;
    end else if (ph == PH_A || ph == PH_B) begin
      case (sel)
        SEL_EXOP: begin
          if (nd != 0 && !side_b && k[2]) begin lop = 1; ph = PH_B; nd = 0; sg = 0; end
          else if (nd != 0 && side_b && k[3]) begin exe = 1; ph = PH_W; wc = 0; end
        end
        SEL_SUB: if (nd == 0) begin
          if (sg) bk = 1; else ld = 1;
          sg = !sg;
        end
        SEL_DIG: if (nd < MAX_DIGITS) begin ld = 1; nd++; end
        SEL_MR:  begin ldm = 1; nd = MAX_DIGITS; end
        SEL_BK:  begin
          if (nd != 0) begin bk = 1; nd--; end
          else if (sg) begin bk = 1; sg = 0; end
        end
        default: ;
      endcase
      if (idle_start && !ld && !bk && !ldm) rso = 1;
    end else if (ph == PH_W) begin
      if (k[9]) ph = k[10] ? PH_E : PH_R;
      else begin
        wc++;
        if (wc == ALU_TIMEOUT) ph = PH_E;
      end
    end else if (ph == PH_R) begin
      if (sel == SEL_EXOP && k[2]) begin chn = 1; lop = 1; ph = PH_B; nd = 0; sg = 0; end
    end
    es = {ld && !side_b, ld && side_b, bk && !side_b, bk && side_b, ldm && !side_b, ldm && side_b,
          k[7] && mem_ok, k[8] && mem_ok, lop, exe, chn, rso};
  endtask

  task automatic cyc(input logic [10:0] k);
    logic [11:0] es;
    @(negedge clock);
    cyc_no++;
    chk($sformatf("regs@%0d", cyc_no), 32'(w_obs_reg), 32'(exp_regs()));
    set_keys(k);
    #1;
    model_step(k, es);
    chk($sformatf("strobes@%0d keys=%03h", cyc_no, k), 32'(w_obs_str), 32'(es));
  endtask

  task automatic do_reset(input logic [10:0] k);
    @(negedge clock);
    reset_n = 1'b0;
    set_keys(k);
    #1;
    chk("reset_strobes", 32'(w_obs_str), 32'd0);
    chk("reset_regs", 32'(w_obs_reg), 32'd0);
    @(posedge clock);
    #1;
    chk("reset_hold_strobes", 32'(w_obs_str), 32'd0);
    chk("reset_hold_regs", 32'(w_obs_reg), 32'd0);
    ph = PH_A; nd = 0; sg = 0; wc = 0;
    @(negedge clock);
    set_keys(K_NONE);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [10:0] k;
    int r;
    reset_n = 1'b0;
    set_keys(K_NONE);
    do_reset(K_DIG | K_EX | K_MS);

    // 12 + 3 =, done three cycles after execute
    cyc(K_DIG); cyc(K_DIG); cyc(K_OP); cyc(K_DIG); cyc(K_EX);
    cyc(K_NONE); cyc(K_NONE); cyc(K_DONE); cyc(K_NONE);
    // chain result into next operation
    cyc(K_OP); cyc(K_NONE);
    // digit limit
    cyc(K_CLR); repeat (5) cyc(K_DIG); cyc(K_NONE);
    // sign and backspace to empty
    cyc(K_CLR); cyc(K_SUB); cyc(K_DIG); cyc(K_BK); cyc(K_BK); cyc(K_NONE);
    // timeout into ERROR, keys ignored, then clear
    cyc(K_DIG); cyc(K_OP); cyc(K_DIG); cyc(K_EX | K_DONE);
    repeat (ALU_TIMEOUT) cyc(K_NONE);
    cyc(K_DIG | K_MS); cyc(K_OP); cyc(K_CLR); cyc(K_NONE);
    // clear beats a simultaneous digit
    cyc(K_DIG); cyc(K_DIG | K_CLR); cyc(K_NONE);
    // memory recall, negative B, ALU error
    cyc(K_MR); cyc(K_DIG); cyc(K_OP); cyc(K_SUB); cyc(K_MR); cyc(K_BK);
    cyc(K_EX); cyc(K_DONE | K_AERR); cyc(K_MC); cyc(K_CLR);
    // async reset while waiting, then a stray done
    cyc(K_DIG); cyc(K_OP); cyc(K_DIG); cyc(K_EX); cyc(K_NONE);
    do_reset(K_DONE | K_DIG);
    cyc(K_DONE); cyc(K_NONE);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      k = K_NONE;
      else if (r < 45) k = K_DIG;
      else if (r < 53) k = K_SUB;
      else if (r < 63) k = K_OP;
      else if (r < 73) k = K_EX;
      else if (r < 83) k = K_BK;
      else if (r < 90) k = K_MR;
      else if (r < 93) k = K_CLR | (11'($urandom) & 11'h05F);
      else             k = K_NONE;
      if ($urandom_range(0, 9) == 0) k = k | K_MS;
      if ($urandom_range(0, 9) == 0) k = k | K_MC;
      if ((ph == PH_W) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0)) begin
        k = k | K_DONE;
        if ($urandom_range(0, 2) == 0) k = k | K_AERR;
      end
      cyc(k);
    end
    cyc(K_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
